// File: rtl/mac_rx_axis_buffer.sv
// Store-and-forward buffer between the MAC RX client FIFO and an AXI4-Stream sink.
// Only complete, error-free packets are replayed; runts, missing-EOP and oversize packets are dropped.
module mac_rx_axis_buffer #(
  parameter int unsigned DEPTH         = 2048,
  parameter int unsigned PKT_DEPTH     = 64,
  parameter int unsigned MAX_PKT_WORDS = 512
) (
  input  logic        mac_clk_i,
  input  logic        mac_rst_n_i,
  input  logic [31:0] mac_rxd_i,
  input  logic [1:0]  mac_ben_i,
  input  logic        mac_rxda_i,
  input  logic        mac_rxsop_i,
  input  logic        mac_rxeop_i,
  input  logic        mac_rxdv_i,
  output logic        mac_rxrqrd_o,
  output logic [31:0] m_axis_tdata_o,
  output logic [3:0]  m_axis_tkeep_o,
  output logic        m_axis_tlast_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic [15:0] drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(PKT_DEPTH);
  localparam int unsigned CW = $clog2(MAX_PKT_WORDS + 2);

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DISCARD} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  wstate_t       w_state;
  rstate_t       r_state;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_q;
  logic [CW+3:0] len_fifo [PKT_DEPTH];
  logic [AW:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [PW:0]   pf_wr, pf_rd;
  logic [CW-1:0] wcnt, rcnt, bcnt;
  logic [3:0]    keep_last;

  logic          oversize_c, wen_c, commit_c, drop_c, pf_nonempty_c, ren_c;
  logic [AW:0]   waddr_c, raddr_c, free_c;
  logic [PW:0]   pf_free_c;
  logic [CW-1:0] len_c;
  logic [3:0]    last_keep_c;

  // Write-side decode; a SOP word always lands at commit_ptr, which also restarts a packet missing its EOP
  always_comb begin
    last_keep_c   = 4'b1111 << mac_ben_i;
    oversize_c    = mac_rxdv_i && (w_state == W_PKT) && !mac_rxsop_i && !mac_rxeop_i &&
                    (wcnt == CW'(MAX_PKT_WORDS));
    wen_c         = mac_rxdv_i && (mac_rxsop_i || ((w_state == W_PKT) && !oversize_c));
    waddr_c       = mac_rxsop_i ? commit_ptr : wr_ptr;
    commit_c      = wen_c && mac_rxeop_i;
    len_c         = mac_rxsop_i ? CW'(1) : wcnt + CW'(1);
    drop_c        = mac_rxdv_i && (w_state == W_PKT) && (mac_rxsop_i || oversize_c);
    free_c        = (AW+1)'(DEPTH) - (wr_ptr - rd_ptr);
    pf_free_c     = (PW+1)'(PKT_DEPTH) - (pf_wr - pf_rd);
    pf_nonempty_c = (pf_wr != pf_rd);
  end

  // Read-side prefetch: ram_q always holds the word after the one in the output register
  always_comb begin
    ren_c   = 1'b0;
    raddr_c = rd_ptr;
    case (r_state)
      R_IDLE:   ren_c = pf_nonempty_c;
      R_FETCH: begin
        ren_c   = 1'b1;
        raddr_c = rd_ptr + (AW+1)'(1);
      end
      R_STREAM: begin
        ren_c   = m_axis_tvalid_o && m_axis_tready_i && !m_axis_tlast_o;
        raddr_c = rd_ptr + (AW+1)'(2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge mac_clk_i) begin
    if (wen_c) mem[waddr_c[AW-1:0]] <= mac_rxd_i;
    if (ren_c) ram_q <= mem[raddr_c[AW-1:0]];
    if (commit_c) len_fifo[pf_wr[PW-1:0]] <= {len_c, last_keep_c};
  end

  // Write FSM, request generation and drop counter
  always_ff @(posedge mac_clk_i) begin
    if (!mac_rst_n_i) begin
      w_state      <= W_IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      pf_wr        <= '0;
      wcnt         <= '0;
      drop_cnt_o   <= '0;
      mac_rxrqrd_o <= 1'b0;
    end else begin
      mac_rxrqrd_o <= mac_rxda_i && (free_c >= (AW+1)'(3)) && (pf_free_c >= (PW+1)'(2));
      if (wen_c) wr_ptr <= waddr_c + (AW+1)'(1);
      if (oversize_c) wr_ptr <= commit_ptr;
      if (commit_c) begin
        commit_ptr <= waddr_c + (AW+1)'(1);
        pf_wr      <= pf_wr + (PW+1)'(1);
      end
      if (drop_c && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
      if (mac_rxdv_i) begin
        if (mac_rxsop_i) begin
          wcnt    <= CW'(1);
          w_state <= mac_rxeop_i ? W_IDLE : W_PKT;
        end else if (w_state == W_PKT) begin
          if (oversize_c) begin
            w_state <= W_DISCARD;
          end else begin
            wcnt <= wcnt + CW'(1);
            if (mac_rxeop_i) w_state <= W_IDLE;
          end
        end else if ((w_state == W_DISCARD) && mac_rxeop_i) begin
          w_state <= W_IDLE;
        end
      end
    end
  end

  // Read FSM and AXI4-Stream output register
  always_ff @(posedge mac_clk_i) begin
    if (!mac_rst_n_i) begin
      r_state         <= R_IDLE;
      rd_ptr          <= '0;
      pf_rd           <= '0;
      rcnt            <= '0;
      bcnt            <= '0;
      keep_last       <= '0;
      m_axis_tdata_o  <= '0;
      m_axis_tkeep_o  <= '0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tvalid_o <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (pf_nonempty_c) begin
            {rcnt, keep_last} <= len_fifo[pf_rd[PW-1:0]];
            pf_rd             <= pf_rd + (PW+1)'(1);
            r_state           <= R_FETCH;
          end
        end
        R_FETCH: begin
          m_axis_tdata_o  <= ram_q;
          m_axis_tvalid_o <= 1'b1;
          bcnt            <= CW'(1);
          m_axis_tlast_o  <= (rcnt == CW'(1));
          m_axis_tkeep_o  <= (rcnt == CW'(1)) ? keep_last : 4'b1111;
          r_state         <= R_STREAM;
        end
        R_STREAM: begin
          if (m_axis_tvalid_o && m_axis_tready_i) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
            if (m_axis_tlast_o) begin
              m_axis_tvalid_o <= 1'b0;
              m_axis_tlast_o  <= 1'b0;
              r_state         <= R_IDLE;
            end else begin
              m_axis_tdata_o <= ram_q;
              bcnt           <= bcnt + CW'(1);
              m_axis_tlast_o <= (bcnt + CW'(1) == rcnt);
              m_axis_tkeep_o <= (bcnt + CW'(1) == rcnt) ? keep_last : 4'b1111;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_axis_buffer.sv
// Directed bench for mac_rx_axis_buffer: table of well-formed packets plus drop, backpressure and reset sequences.
module tb_mac_rx_axis_buffer;

  logic        mac_clk_i = 1'b0;
  logic        mac_rst_n_i;
  logic [31:0] mac_rxd_i;
  logic [1:0]  mac_ben_i;
  logic        mac_rxda_i;
  logic        mac_rxsop_i;
  logic        mac_rxeop_i;
  logic        mac_rxdv_i;
  logic        mac_rxrqrd_o;
  logic [31:0] m_axis_tdata_o;
  logic [3:0]  m_axis_tkeep_o;
  logic        m_axis_tlast_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i;
  logic [15:0] drop_cnt_o;

  mac_rx_axis_buffer #(.DEPTH(16), .PKT_DEPTH(4), .MAX_PKT_WORDS(8)) dut (
    .mac_clk_i       (mac_clk_i),
    .mac_rst_n_i     (mac_rst_n_i),
    .mac_rxd_i       (mac_rxd_i),
    .mac_ben_i       (mac_ben_i),
    .mac_rxda_i      (mac_rxda_i),
    .mac_rxsop_i     (mac_rxsop_i),
    .mac_rxeop_i     (mac_rxeop_i),
    .mac_rxdv_i      (mac_rxdv_i),
    .mac_rxrqrd_o    (mac_rxrqrd_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tkeep_o  (m_axis_tkeep_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tready_i (m_axis_tready_i),
    .drop_cnt_o      (drop_cnt_o)
  );

  always #5 mac_clk_i = ~mac_clk_i;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ben;
    logic        sop;
    logic        eop;
  } mac_word_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int         nwords;
    logic [1:0] ben;
    logic [3:0] exp_keep;
  } vec_t;

  mac_word_t mac_q[$];
  beat_t     got[$];
  int        tests  = 0;
  int        errors = 0;

  function automatic logic [31:0] pat(input int base, input int i);
    return {8'hA5, 8'(base), 8'hC3, 8'(i)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input int n, input int base, input logic [1:0] ben, input bit term);
    mac_word_t w;
    for (int i = 0; i < n; i++) begin
      w.d   = pat(base, i);
      w.ben = ben;
      w.sop = (i == 0);
      w.eop = term && (i == n - 1);
      mac_q.push_back(w);
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge mac_clk_i);
      #1;
      k++;
    end
  endtask

  task automatic check_pkt(input string name, input int n, input int base, input logic [3:0] keep_last);
    beat_t b;
    wait_beats(n, 400);
    if (got.size() < n) check({name, "_beats_timeout"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && got.size() > 0; i++) begin
      b = got.pop_front();
      check({name, "_tdata"}, b.d, pat(base, i));
      check({name, "_tkeep"}, 32'(b.keep), (i == n - 1) ? 32'(keep_last) : 32'hF);
      check({name, "_tlast"}, 32'(b.last), (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_no_extra(input string name);
    repeat (10) @(posedge mac_clk_i);
    #2;
    check({name, "_extra_beats"}, 32'(got.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge mac_clk_i);
    #2;
    mac_rst_n_i = 1'b0;
    mac_q.delete();
    @(posedge mac_clk_i);
    #2;
    mac_rst_n_i = 1'b1;
    got.delete();
  endtask

  // MAC RX FIFO model: one word per cycle whenever a read request is outstanding
  initial begin
    mac_word_t w;
    mac_rxd_i   = '0;
    mac_ben_i   = '0;
    mac_rxda_i  = 1'b0;
    mac_rxsop_i = 1'b0;
    mac_rxeop_i = 1'b0;
    mac_rxdv_i  = 1'b0;
    forever begin
      @(posedge mac_clk_i);
      #1;
      mac_rxda_i = (mac_q.size() > 0);
      if (mac_rxrqrd_o && mac_q.size() > 0) begin
        w           = mac_q.pop_front();
        mac_rxd_i   = w.d;
        mac_ben_i   = w.ben;
        mac_rxsop_i = w.sop;
        mac_rxeop_i = w.eop;
        mac_rxdv_i  = 1'b1;
      end else begin
        mac_rxsop_i = 1'b0;
        mac_rxeop_i = 1'b0;
        mac_rxdv_i  = 1'b0;
      end
    end
  end

  // Stream monitor; handshake sampled mid-cycle
  initial begin
    forever begin
      @(negedge mac_clk_i);
      if (m_axis_tvalid_o && m_axis_tready_i)
        got.push_back('{d: m_axis_tdata_o, keep: m_axis_tkeep_o, last: m_axis_tlast_o});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{nwords: 4, ben: 2'b10, exp_keep: 4'b1100};
    vecs[1] = '{nwords: 1, ben: 2'b11, exp_keep: 4'b1000};
    vecs[2] = '{nwords: 2, ben: 2'b00, exp_keep: 4'b1111};
    vecs[3] = '{nwords: 8, ben: 2'b01, exp_keep: 4'b1110};
    vecs[4] = '{nwords: 3, ben: 2'b11, exp_keep: 4'b1000};

    mac_rst_n_i     = 1'b0;
    m_axis_tready_i = 1'b1;
    repeat (3) @(posedge mac_clk_i);
    #2;
    check("rst_rqrd",  32'(mac_rxrqrd_o),    32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid_o), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast_o),  32'd0);
    check("rst_tkeep", 32'(m_axis_tkeep_o),  32'd0);
    check("rst_tdata", m_axis_tdata_o,       32'd0);
    check("rst_drop",  32'(drop_cnt_o),      32'd0);
    mac_rst_n_i = 1'b1;

    for (int v = 0; v < 5; v++) begin
      send_pkt(vecs[v].nwords, v + 1, vecs[v].ben, 1'b1);
      check_pkt($sformatf("vec%0d", v), vecs[v].nwords, v + 1, vecs[v].exp_keep);
    end
    check_no_extra("vec");
    check("vec_drop", 32'(drop_cnt_o), 32'd0);

    // Packet without EOP is replaced by the following SOP
    do_reset();
    send_pkt(3, 16, 2'b00, 1'b0);
    send_pkt(2, 17, 2'b01, 1'b1);
    check_pkt("noeop", 2, 17, 4'b1110);
    check_no_extra("noeop");
    check("noeop_drop", 32'(drop_cnt_o), 32'd1);

    // 12-word packet exceeds the 8-word limit
    do_reset();
    send_pkt(12, 32, 2'b00, 1'b1);
    send_pkt(5, 33, 2'b10, 1'b1);
    check_pkt("oversize", 5, 33, 4'b1100);
    check_no_extra("oversize");
    check("oversize_drop", 32'(drop_cnt_o), 32'd1);

    // Sink stalled: buffer fills, request drops, nothing lost once released
    do_reset();
    m_axis_tready_i = 1'b0;
    send_pkt(6, 48, 2'b00, 1'b1);
    send_pkt(6, 49, 2'b00, 1'b1);
    send_pkt(6, 50, 2'b00, 1'b1);
    repeat (80) @(posedge mac_clk_i);
    #2;
    check("full_rqrd_low",   32'(mac_rxrqrd_o),          32'd0);
    check("full_mac_pending", 32'(mac_q.size() > 0),      32'd1);
    check("full_hold_tvalid", 32'(m_axis_tvalid_o),       32'd1);
    check("full_hold_tdata", m_axis_tdata_o,              pat(48, 0));
    check("full_hold_tlast", 32'(m_axis_tlast_o),         32'd0);
    m_axis_tready_i = 1'b1;
    check_pkt("full_p0", 6, 48, 4'b1111);
    check_pkt("full_p1", 6, 49, 4'b1111);
    check_pkt("full_p2", 6, 50, 4'b1111);
    check_no_extra("full");
    check("full_drop", 32'(drop_cnt_o), 32'd0);

    // Reset during the third beat of an 8-word packet
    do_reset();
    send_pkt(8, 64, 2'b00, 1'b1);
    wait_beats(2, 400);
    check("mid_two_beats", 32'(got.size() >= 2), 32'd1);
    @(posedge mac_clk_i);
    #2;
    mac_rst_n_i = 1'b0;
    mac_q.delete();
    @(posedge mac_clk_i);
    #2;
    check("mid_rst_tvalid", 32'(m_axis_tvalid_o), 32'd0);
    check("mid_rst_drop",  32'(drop_cnt_o),      32'd0);
    mac_rst_n_i = 1'b1;
    got.delete();
    check_no_extra("mid_rst_flush");
    send_pkt(3, 65, 2'b11, 1'b1);
    check_pkt("mid_after", 3, 65, 4'b1000);
    check_no_extra("mid_after");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
